// File: rtl/deck_dealer.sv
// deck_dealer: random card dealer for a 108-card deck.
//
// A 64-entry count table tracks how many copies of each card code remain.
// A free-running 8-bit LFSR picks a starting code; the dealer then probes
// upward (mod 64) until it finds a code with a non-zero count and deals it.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_init       one-cycle pulse: restore full deck and reseed LFSR
//   i_seed[7:0]  LFSR seed, sampled with i_init (zero maps to 8'hA5)
//   i_draw       draw request, only honoured in IDLE
//   o_card[5:0]  dealt card {colour[1:0], value[3:0]}, held until next draw
//   o_drawn      one-cycle pulse when o_card is updated
//   o_idle       high while ready to accept i_draw
//   o_remaining  cards left in the pile (0-108)
//   o_empty      high when o_remaining is zero
//
// Build option: define DECK_REFILL_EN to refill an empty deck on a draw
// request (through a one-cycle REFILL state) instead of ignoring it.

module deck_dealer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_init,
    input  logic [7:0] i_seed,
    input  logic       i_draw,
    output logic [5:0] o_card,
    output logic       o_drawn,
    output logic       o_idle,
    output logic [6:0] o_remaining,
    output logic       o_empty
);

    localparam int unsigned CODE_W    = 6;
    localparam int unsigned NUM_CODES = 64;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned LFSR_W    = 8;
    localparam int unsigned REM_W     = 7;
    localparam int unsigned DECK_SIZE = 108;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 8'hA5;
    localparam logic [CODE_W-1:0] CODE_WILD    = 6'b001101;
    localparam logic [CODE_W-1:0] CODE_WILD4   = 6'b011110;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PICK    = 3'd1;
    localparam logic [2:0] S_PROBE   = 3'd2;
    localparam logic [2:0] S_DELIVER = 3'd3;
`ifdef DECK_REFILL_EN
    localparam logic [2:0] S_REFILL  = 3'd4;
`endif

    // Number of copies of a code in a fresh deck.
    function automatic logic [CNT_W-1:0] full_count(input logic [CODE_W-1:0] code);
        logic [3:0] value;
        value = code[3:0];
        if (code == CODE_WILD || code == CODE_WILD4) begin
            return CNT_W'(4);
        end else if (value == 4'd0) begin
            return CNT_W'(1);
        end else if (value <= 4'd12) begin
            return CNT_W'(2);
        end else begin
            return CNT_W'(0);
        end
    endfunction

    logic [2:0]          state_q,  state_d;
    logic [CODE_W-1:0]   cand_q,   cand_d;
    logic [LFSR_W-1:0]   lfsr_q,   lfsr_d;
    logic [CNT_W-1:0]    count_q [NUM_CODES];
    logic [CNT_W-1:0]    count_d [NUM_CODES];
    logic [REM_W-1:0]    rem_q,    rem_d;
    logic [CODE_W-1:0]   card_q,   card_d;
    logic                drawn_q,  drawn_d;
    logic                idle_q,   idle_d;
    logic                empty_q,  empty_d;
    logic                lfsr_fb;

    // LFSR feedback for x^8+x^6+x^5+x^4+1.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_fb};
        count_d = count_q;
        rem_d   = rem_q;
        card_d  = card_q;
        drawn_d = 1'b0;

        if (i_init) begin
            // Init overrides any state, aborting an in-flight draw.
            state_d = S_IDLE;
            lfsr_d  = (i_seed == '0) ? LFSR_DEFAULT : i_seed;
            for (int i = 0; i < NUM_CODES; i++) begin
                count_d[i] = full_count(CODE_W'(i));
            end
            rem_d = REM_W'(DECK_SIZE);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_draw && !empty_q) begin
                        state_d = S_PICK;
                    end
`ifdef DECK_REFILL_EN
                    else if (i_draw && empty_q) begin
                        state_d = S_REFILL;
                    end
`endif
                end
`ifdef DECK_REFILL_EN
                S_REFILL: begin
                    // Restore the deck but keep the LFSR running unseeded.
                    for (int i = 0; i < NUM_CODES; i++) begin
                        count_d[i] = full_count(CODE_W'(i));
                    end
                    rem_d   = REM_W'(DECK_SIZE);
                    state_d = S_PICK;
                end
`endif
                S_PICK: begin
                    cand_d  = lfsr_q[CODE_W-1:0];
                    state_d = S_PROBE;
                end
                S_PROBE: begin
                    // Walk upward until a code with copies left is found.
                    if (count_q[cand_q] != '0) begin
                        state_d = S_DELIVER;
                    end else begin
                        cand_d = cand_q + CODE_W'(1);
                    end
                end
                S_DELIVER: begin
                    count_d[cand_q] = count_q[cand_q] - CNT_W'(1);
                    rem_d           = rem_q - REM_W'(1);
                    card_d          = cand_q;
                    drawn_d         = 1'b1;
                    state_d         = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        idle_d  = (state_d == S_IDLE);
        empty_d = (rem_d == '0);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            lfsr_q  <= LFSR_DEFAULT;
            for (int i = 0; i < NUM_CODES; i++) begin
                count_q[i] <= full_count(CODE_W'(i));
            end
            rem_q   <= REM_W'(DECK_SIZE);
            card_q  <= '0;
            drawn_q <= 1'b0;
            idle_q  <= 1'b1;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            card_q  <= card_d;
            drawn_q <= drawn_d;
            idle_q  <= idle_d;
            empty_q <= empty_d;
        end
    end

    assign o_card      = card_q;
    assign o_drawn     = drawn_q;
    assign o_idle      = idle_q;
    assign o_remaining = rem_q;
    assign o_empty     = empty_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Self-checking bench for deck_dealer: randomized seeds and draw traffic
// checked against a card-count model of the deck.
module tb_deck_dealer;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_init = 1'b0;
    logic [7:0] i_seed = 8'h00;
    logic       i_draw = 1'b0;
    logic [5:0] o_card;
    logic       o_drawn;
    logic       o_idle;
    logic [6:0] o_remaining;
    logic       o_empty;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt [64];
    int model_rem;

    deck_dealer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_init      (i_init),
        .i_seed      (i_seed),
        .i_draw      (i_draw),
        .o_card      (o_card),
        .o_drawn     (o_drawn),
        .o_idle      (o_idle),
        .o_remaining (o_remaining),
        .o_empty     (o_empty)
    );

    always #5 i_clk = ~i_clk;

    // Copies of each code in a fresh deck, from colour/value rules.
    function automatic int deck_count(input int code);
        int colour;
        int value;
        colour = code / 16;
        value  = code % 16;
        case (value)
            0:       return 1;
            13:      return (colour == 0) ? 4 : 0;
            14:      return (colour == 1) ? 4 : 0;
            15:      return 0;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_cnt[i] = deck_count(i);
        model_rem = 108;
    endtask

    task automatic do_init(input logic [7:0] s);
        @(negedge i_clk);
        i_init = 1'b1;
        i_seed = s;
        @(negedge i_clk);
        i_init = 1'b0;
        model_reset();
    endtask

    // Issue one draw from IDLE; lat = cycles from the sampling edge to o_drawn.
    task automatic do_draw(output logic [5:0] card, output int lat, output bit got);
        got  = 1'b0;
        lat  = 0;
        card = '0;
        i_draw = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_draw = 1'b0;
        for (int n = 2; n <= 72 && !got; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_drawn) begin
                got  = 1'b1;
                lat  = n - 1;
                card = o_card;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #3;
        n_checks++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b want=1", o_idle); end
        n_checks++; if (o_drawn !== 1'b0) begin n_fail++; $display("FAIL reset_drawn got=%b want=0", o_drawn); end
        n_checks++; if (o_card !== 6'd0) begin n_fail++; $display("FAIL reset_card got=%0d want=0", o_card); end
        n_checks++; if (o_remaining !== 7'd108) begin n_fail++; $display("FAIL reset_remaining got=%0d want=108", o_remaining); end
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty got=%b want=0", o_empty); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    // First card after init is fully determined by the seed.
    task automatic test_seed(input logic [7:0] s);
        logic [7:0] eff;
        logic [7:0] v;
        logic [5:0] cand;
        logic [5:0] card;
        int miss;
        int lat;
        bit got;
        eff = (s == 8'h00) ? 8'hA5 : s;
        do_init(s);
        n_checks++; if (o_remaining !== 7'd108) begin n_fail++; $display("FAIL seed_remaining seed=%h got=%0d want=108", s, o_remaining); end
        n_checks++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL seed_idle seed=%h got=%b want=1", s, o_idle); end
        v    = lfsr_next(eff);
        cand = v[5:0];
        miss = 0;
        while (deck_count(int'(cand)) == 0) begin
            cand = cand + 6'd1;
            miss++;
        end
        do_draw(card, lat, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL seed_draw_timeout seed=%h got=0 want=1", s); end
        n_checks++; if (card !== cand) begin n_fail++; $display("FAIL seed_first_card seed=%h got=%h want=%h", s, card, cand); end
        n_checks++; if (lat != 3 + miss) begin n_fail++; $display("FAIL seed_latency seed=%h got=%0d want=%0d", s, lat, 3 + miss); end
    endtask

    // Drain the whole deck; the final card must be the only code left.
    task automatic test_full_deck();
        int hist [64];
        logic [5:0] card;
        logic [5:0] last;
        int lat;
        bit got;
        for (int i = 0; i < 64; i++) hist[i] = 0;
        do_init(8'($urandom_range(0, 255)));
        for (int k = 0; k < 108; k++) begin
            last = '0;
            for (int i = 0; i < 64; i++) if (model_cnt[i] > 0) last = 6'(i);
            do_draw(card, lat, got);
            n_checks++;
            if (got !== 1'b1) begin
                n_fail++; $display("FAIL deck_draw_timeout draw=%0d got=0 want=1", k);
                break;
            end
            n_checks++;
            if (k == 107) begin
                if (card !== last) begin n_fail++; $display("FAIL deck_last_card got=%h want=%h", card, last); end
            end else if (model_cnt[card] <= 0) begin
                n_fail++; $display("FAIL deck_card_valid draw=%0d got=%h want=code_with_copies_left", k, card);
            end
            n_checks++; if (lat < 3 || lat > 66) begin n_fail++; $display("FAIL deck_latency draw=%0d got=%0d want=3..66", k, lat); end
            model_cnt[card]--;
            hist[card]++;
            model_rem--;
            n_checks++; if (o_remaining !== 7'(model_rem)) begin n_fail++; $display("FAIL deck_remaining draw=%0d got=%0d want=%0d", k, o_remaining, model_rem); end
        end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL deck_empty got=%b want=1", o_empty); end
        n_checks++; if (o_remaining !== 7'd0) begin n_fail++; $display("FAIL deck_drained got=%0d want=0", o_remaining); end
        for (int i = 0; i < 64; i++) begin
            n_checks++; if (hist[i] != deck_count(i)) begin n_fail++; $display("FAIL deck_histogram code=%h got=%0d want=%0d", i, hist[i], deck_count(i)); end
        end
    endtask

    task automatic test_empty_draw();
`ifdef DECK_REFILL_EN
        logic [5:0] card;
        int lat;
        bit got;
        do_draw(card, lat, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL refill_draw_timeout got=0 want=1"); end
        n_checks++; if (lat < 4 || lat > 67) begin n_fail++; $display("FAIL refill_latency got=%0d want=4..67", lat); end
        n_checks++; if (deck_count(int'(card)) == 0) begin n_fail++; $display("FAIL refill_card_valid got=%h want=deck_code", card); end
        n_checks++; if (o_remaining !== 7'd107) begin n_fail++; $display("FAIL refill_remaining got=%0d want=107", o_remaining); end
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL refill_empty got=%b want=0", o_empty); end
`else
        bit saw_drawn;
        bit saw_busy;
        saw_drawn = 1'b0;
        saw_busy  = 1'b0;
        i_draw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_drawn) saw_drawn = 1'b1;
            if (!o_idle) saw_busy = 1'b1;
        end
        i_draw = 1'b0;
        n_checks++; if (saw_drawn !== 1'b0) begin n_fail++; $display("FAIL empty_no_drawn got=%b want=0", saw_drawn); end
        n_checks++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL empty_stays_idle got_busy=%b want=0", saw_busy); end
        n_checks++; if (o_remaining !== 7'd0) begin n_fail++; $display("FAIL empty_remaining got=%0d want=0", o_remaining); end
`endif
    endtask

    // Init two cycles after an accepted draw aborts it.
    task automatic test_init_abort();
        bit saw_drawn;
        do_init(8'($urandom_range(1, 255)));
        i_draw = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_draw = 1'b0;
        n_checks++; if (o_idle !== 1'b0) begin n_fail++; $display("FAIL abort_accepted got_idle=%b want=0", o_idle); end
        saw_drawn = o_drawn;
        @(posedge i_clk);
        @(negedge i_clk);
        if (o_drawn) saw_drawn = 1'b1;
        i_init = 1'b1;
        i_seed = 8'($urandom);
        @(posedge i_clk);
        @(negedge i_clk);
        i_init = 1'b0;
        n_checks++; if (o_remaining !== 7'd108) begin n_fail++; $display("FAIL abort_remaining got=%0d want=108", o_remaining); end
        n_checks++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL abort_idle got=%b want=1", o_idle); end
        if (o_drawn) saw_drawn = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_drawn) saw_drawn = 1'b1;
        end
        n_checks++; if (saw_drawn !== 1'b0) begin n_fail++; $display("FAIL abort_no_drawn got=%b want=0", saw_drawn); end
        model_reset();
    endtask

    // Simultaneous init and draw: the draw is dropped.
    task automatic test_init_and_draw();
        bit saw_drawn;
        saw_drawn = 1'b0;
        @(negedge i_clk);
        i_init = 1'b1;
        i_draw = 1'b1;
        i_seed = 8'($urandom);
        @(negedge i_clk);
        i_init = 1'b0;
        i_draw = 1'b0;
        n_checks++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL simul_idle got=%b want=1", o_idle); end
        for (int k = 0; k < 70; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_drawn) saw_drawn = 1'b1;
        end
        n_checks++; if (saw_drawn !== 1'b0) begin n_fail++; $display("FAIL simul_no_drawn got=%b want=0", saw_drawn); end
        n_checks++; if (o_remaining !== 7'd108) begin n_fail++; $display("FAIL simul_remaining got=%0d want=108", o_remaining); end
        model_reset();
    endtask

    // Held draw for 40 cycles: at most 10 cards, spaced at least 4 cycles.
    task automatic test_held_draw();
        int pulses;
        int last_cyc;
        int min_gap;
        bit bad_card;
        do_init(8'($urandom_range(0, 255)));
        pulses   = 0;
        last_cyc = -100;
        min_gap  = 1000;
        bad_card = 1'b0;
        i_draw = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (c == 39) i_draw = 1'b0;
            if (o_drawn) begin
                if (c < 40) pulses++;
                if (c - last_cyc < min_gap) min_gap = c - last_cyc;
                last_cyc = c;
                if (model_cnt[o_card] <= 0) bad_card = 1'b1;
                model_cnt[o_card]--;
                model_rem--;
            end
        end
        n_checks++; if (pulses > 10) begin n_fail++; $display("FAIL held_pulse_count got=%0d want=<=10", pulses); end
        n_checks++; if (pulses < 1) begin n_fail++; $display("FAIL held_progress got=%0d want=>=1", pulses); end
        n_checks++; if (min_gap < 4) begin n_fail++; $display("FAIL held_spacing got=%0d want=>=4", min_gap); end
        n_checks++; if (bad_card !== 1'b0) begin n_fail++; $display("FAIL held_card_valid got=%b want=0", bad_card); end
        n_checks++; if (o_remaining !== 7'(model_rem)) begin n_fail++; $display("FAIL held_remaining got=%0d want=%0d", o_remaining, model_rem); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_seed(8'h00);
        test_seed(8'($urandom_range(1, 255)));
        test_full_deck();
        test_empty_draw();
        test_init_abort();
        test_init_and_draw();
        test_held_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deck_dealer.md
DECK_DEALER -- requirements
Module: deck_dealer

Interface
REQ-001 SHALL have port i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port i_init  input  1  one-cycle pulse: restore full 108-card deck and reseed.
REQ-004 SHALL have port i_seed  input  8  LFSR seed, sampled on i_init.
REQ-005 SHALL have port i_draw  input  1  draw request from a player/computer, sampled only in IDLE.
REQ-006 SHALL have port o_card  output  6  drawn card: [5:4] colour (00 red, 01 yellow, 10 green, 11 blue), [3:0] value (0-9, 10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild-draw-four).
REQ-007 SHALL have port o_drawn  output  1  one-cycle pulse; o_card valid in that cycle and held until the next draw.
REQ-008 SHALL have port o_idle  output  1  high only in IDLE, i.e. ready to accept i_draw.
REQ-009 SHALL have port o_remaining  output  7  cards left in the pile, 0-108.
REQ-010 SHALL have port o_empty  output  1  high when o_remaining == 0.

Function
REQ-011 SHALL keep a 64-entry x 3-bit count table indexed by card code; full deck per colour: value 0 = 1, values 1-12 = 2; code 6'b001101 (wild) = 4; code 6'b011110 (wild-draw-four) = 4; all other codes = 0; total 108.
REQ-012 SHALL run an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping every cycle regardless of state; a zero seed SHALL be replaced by 8'hA5.
REQ-013 SHALL implement FSM IDLE -> PICK -> PROBE -> DELIVER -> IDLE.
REQ-014 IDLE: on i_draw with o_empty low SHALL go to PICK; otherwise SHALL stay in IDLE.
REQ-015 PICK: SHALL latch candidate = LFSR[5:0] and go to PROBE.
REQ-016 PROBE: if count[candidate] > 0 SHALL go to DELIVER; otherwise SHALL set candidate = candidate+1 (mod 64) and stay in PROBE.
REQ-017 DELIVER: SHALL decrement count[candidate] and o_remaining, drive o_card = candidate, pulse o_drawn, and return to IDLE.
REQ-018 Latency from the i_draw sample to o_drawn SHALL be 3 cycles minimum and 66 maximum.
REQ-019 A held-high i_draw SHALL yield one card per pass through IDLE, i.e. at most one card per 4 cycles; i_draw outside IDLE SHALL be ignored.
REQ-020 i_init SHALL take priority over everything: in the next cycle counts are full, o_remaining = 108, LFSR = seed, state = IDLE; an in-flight draw SHALL be aborted with no o_drawn pulse.
REQ-021 Simultaneous i_init and i_draw: i_init SHALL win and the draw SHALL be dropped.

Reset
REQ-022 On i_rst_n low, asynchronously: state IDLE, full count table, o_remaining = 108, LFSR = 8'hA5, o_card = 0, o_drawn = 0, o_idle = 1, o_empty = 0.

Configuration
REQ-023 With macro DECK_REFILL_EN defined: i_draw in IDLE with o_empty high SHALL enter state REFILL, restore the full deck in one cycle (o_remaining = 108, LFSR not reseeded), then go to PICK.
REQ-024 Without DECK_REFILL_EN: i_draw while o_empty is high SHALL be ignored; state stays IDLE; o_drawn stays low.

Verification
REQ-025 Reset, then i_init with i_seed = 8'h00 -> LFSR = 8'hA5, o_remaining = 108, o_idle = 1.
REQ-026 108 sequential draws -> 108 o_drawn pulses; code histogram matches REQ-011 exactly; o_remaining counts down to 0; o_empty = 1.
REQ-027 109th draw -> without the macro: no o_drawn and o_idle stays 1; with the macro: REFILL, then o_drawn, then o_remaining = 107.
REQ-028 Deck drained to one card (e.g. 6'b011110) -> next draw returns 6'b011110 within 66 cycles.
REQ-029 i_init asserted two cycles after an accepted i_draw -> no o_drawn pulse; o_remaining = 108 the cycle after.
REQ-030 i_draw held high for 40 cycles from IDLE -> at most 10 o_drawn pulses; consecutive pulses at least 4 cycles apart.
